// File: rtl/sub_top_mem_arb_pkg.sv
// Shared types and helpers for the on-chip RAM arbiter.
//   master_id_t     : identifies the two masters (CPU data master, stream reader)
//   HOLD_W          : hold counter width for the default MAX_HOLD
//   hold_width()    : hold counter width for any MAX_HOLD
//   other_master()  : the master that is not the given one
package sub_top_mem_arb_pkg;

    typedef enum logic [0:0] {
        M_CPU    = 1'b0,
        M_STREAM = 1'b1
    } master_id_t;

    localparam int DEFAULT_MAX_HOLD = 4;
    localparam int HOLD_W           = $clog2(DEFAULT_MAX_HOLD + 1);

    function automatic int hold_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

    function automatic master_id_t other_master(input master_id_t id);
        return (id == M_CPU) ? M_STREAM : M_CPU;
    endfunction

endpackage

// File: rtl/sub_top_rr_hold_arbiter.sv
// Two-requester arbiter with a bounded hold on the last winner.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset; no grant while asserted
//   req    in   [1:0] request per master
//   gnt    out  [1:0] one-hot grant (combinational from req and state)
module sub_top_rr_hold_arbiter
    import sub_top_mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int            HW       = hold_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    master_id_t    last_gnt_r;
    logic [HW-1:0] hold_cnt_r;
    master_id_t    win_s;
    logic          keep_s;
    logic          req_last_s;
    logic          busy_s;

    // Pick the winner; a zero hold count means the last winner has no live
    // streak (reset or an idle cycle), so under contention the other master goes first.
    always_comb begin
        req_last_s = (last_gnt_r == M_STREAM) ? req[1] : req[0];
        keep_s     = (hold_cnt_r != HW'(1'b0)) && (hold_cnt_r < HOLD_MAX) && req_last_s;
        case (req)
            2'b01:   win_s = M_CPU;
            2'b10:   win_s = M_STREAM;
            2'b11:   win_s = keep_s ? last_gnt_r : other_master(last_gnt_r);
            default: win_s = last_gnt_r;
        endcase
    end

    // Turn the winner into a one-hot grant, suppressed while idle or in reset.
    always_comb begin
        busy_s = (req != 2'b00) && !reset;
        if (!busy_s) begin
            gnt = 2'b00;
        end else if (win_s == M_STREAM) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b01;
        end
    end

    // Track the last winner and the length of its current streak.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= M_CPU;
            hold_cnt_r <= HW'(1'b0);
        end else if (busy_s) begin
            if (win_s == last_gnt_r) begin
                if (hold_cnt_r < HOLD_MAX) begin
                    hold_cnt_r <= hold_cnt_r + HW'(1'b1);
                end else begin
                    hold_cnt_r <= hold_cnt_r;
                end
            end else begin
                hold_cnt_r <= HW'(1'b1);
                last_gnt_r <= win_s;
            end
        end else begin
            hold_cnt_r <= HW'(1'b0);
        end
    end

endmodule

// File: rtl/sub_top_onchip_memory_arbiter.sv
// Arbiter in front of the single-port on-chip RAM: master 0 is the CPU data
// master, master 1 the picture/audio stream reader. One access per cycle is
// granted; reads return one cycle later with a readdatavalid pulse.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mN_address/read/write/byteenable/writedata   master N request (N=0,1)
//   mN_waitrequest             request present but not granted this cycle
//   mN_readdata/readdatavalid  read return, pass-through from the RAM
//   mem_*                      RAM s1 port drive; mem_clken tied high
//   mem_readdata               RAM data, valid one cycle after the address
module sub_top_onchip_memory_arbiter
    import sub_top_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              granted_s;
    master_id_t        gnt_id_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_write_s;
    logic [BE_W-1:0]   sel_be_s;
    logic [DATA_W-1:0] sel_wd_s;
    logic              accept_read_s;
    logic              rdv_s;

    logic [ADDR_W-1:0] addr_hold_r;
    logic [BE_W-1:0]   be_hold_r;
    logic [DATA_W-1:0] wd_hold_r;
    logic              rd_pend_r;
    master_id_t        rd_id_r;

    // A simultaneous read and write counts as a write: mN_write alone decides the direction.
    assign req_s = {m1_read | m1_write, m0_read | m0_write};

    sub_top_rr_hold_arbiter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    // Select the granted master's request fields.
    always_comb begin
        granted_s = gnt_s[1] | gnt_s[0];
        if (gnt_s[1]) begin
            gnt_id_s    = M_STREAM;
            sel_addr_s  = m1_address;
            sel_write_s = m1_write;
            sel_be_s    = m1_byteenable;
            sel_wd_s    = m1_writedata;
        end else begin
            gnt_id_s    = M_CPU;
            sel_addr_s  = m0_address;
            sel_write_s = m0_write;
            sel_be_s    = m0_byteenable;
            sel_wd_s    = m0_writedata;
        end
        accept_read_s = granted_s & ~sel_write_s;
    end

    // Drive the RAM port; on idle cycles the address/data hold their last value.
    always_comb begin
        mem_chipselect = granted_s;
        mem_write      = granted_s & sel_write_s;
        mem_clken      = 1'b1;
        if (granted_s) begin
            mem_address    = sel_addr_s;
            mem_byteenable = sel_be_s;
            mem_writedata  = sel_wd_s;
        end else begin
            mem_address    = addr_hold_r;
            mem_byteenable = be_hold_r;
            mem_writedata  = wd_hold_r;
        end
    end

    // Remember the last driven RAM fields so idle cycles keep the bus quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_r <= {ADDR_W{1'b0}};
            be_hold_r   <= {BE_W{1'b0}};
            wd_hold_r   <= {DATA_W{1'b0}};
        end else if (granted_s) begin
            addr_hold_r <= sel_addr_s;
            be_hold_r   <= sel_be_s;
            wd_hold_r   <= sel_wd_s;
        end else begin
            addr_hold_r <= addr_hold_r;
            be_hold_r   <= be_hold_r;
            wd_hold_r   <= wd_hold_r;
        end
    end

    // Note which master owns the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_r <= 1'b0;
            rd_id_r   <= M_CPU;
        end else begin
            rd_pend_r <= accept_read_s;
            rd_id_r   <= accept_read_s ? gnt_id_s : rd_id_r;
        end
    end

    // Route the return; gating with reset drops a read whose data lands during reset.
    always_comb begin
        rdv_s            = rd_pend_r & ~reset;
        m0_readdatavalid = rdv_s & (rd_id_r == M_CPU);
        m1_readdatavalid = rdv_s & (rd_id_r == M_STREAM);
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_waitrequest   = req_s[0] & ~gnt_s[0];
        m1_waitrequest   = req_s[1] & ~gnt_s[1];
    end

endmodule

// File: tb/tb_sub_top_onchip_memory_arbiter.sv
// Bench for sub_top_onchip_memory_arbiter: two instances (MAX_HOLD=4 and 1)
// share the master inputs, each with its own behavioural RAM.
module tb_sub_top_onchip_memory_arbiter;

    localparam int MAXH = 4;

    logic        clk;
    logic        reset;
    logic        ram_init;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [10:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;

    logic        h4_m0_waitrequest, h4_m0_readdatavalid, h4_m1_waitrequest, h4_m1_readdatavalid;
    logic [31:0] h4_m0_readdata, h4_m1_readdata, h4_mem_writedata, h4_mem_readdata;
    logic [10:0] h4_mem_address;
    logic        h4_mem_chipselect, h4_mem_write, h4_mem_clken;
    logic [3:0]  h4_mem_byteenable;

    logic        h1_m0_waitrequest, h1_m0_readdatavalid, h1_m1_waitrequest, h1_m1_readdatavalid;
    logic [31:0] h1_m0_readdata, h1_m1_readdata, h1_mem_writedata, h1_mem_readdata;
    logic [10:0] h1_mem_address;
    logic        h1_mem_chipselect, h1_mem_write, h1_mem_clken;
    logic [3:0]  h1_mem_byteenable;

    int checks;
    int errors;

    sub_top_onchip_memory_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(h4_m0_waitrequest), .m0_readdata(h4_m0_readdata),
        .m0_readdatavalid(h4_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(h4_m1_waitrequest), .m1_readdata(h4_m1_readdata),
        .m1_readdatavalid(h4_m1_readdatavalid),
        .mem_address(h4_mem_address), .mem_chipselect(h4_mem_chipselect),
        .mem_write(h4_mem_write), .mem_byteenable(h4_mem_byteenable),
        .mem_writedata(h4_mem_writedata), .mem_clken(h4_mem_clken),
        .mem_readdata(h4_mem_readdata)
    );

    sub_top_onchip_memory_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(h1_m0_waitrequest), .m0_readdata(h1_m0_readdata),
        .m0_readdatavalid(h1_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(h1_m1_waitrequest), .m1_readdata(h1_m1_readdata),
        .m1_readdatavalid(h1_m1_readdatavalid),
        .mem_address(h1_mem_address), .mem_chipselect(h1_mem_chipselect),
        .mem_write(h1_mem_write), .mem_byteenable(h1_mem_byteenable),
        .mem_writedata(h1_mem_writedata), .mem_clken(h1_mem_clken),
        .mem_readdata(h1_mem_readdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural RAMs: registered address, unregistered read data.
    logic [31:0] ram4 [0:2047];
    logic [31:0] ram1 [0:2047];
    logic [10:0] ra4_r, ra1_r;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) ram4[i] <= init_word(i);
        end else if (h4_mem_clken && h4_mem_chipselect && h4_mem_write) begin
            for (int b = 0; b < 4; b++)
                if (h4_mem_byteenable[b]) ram4[h4_mem_address][8*b +: 8] <= h4_mem_writedata[8*b +: 8];
        end
        ra4_r <= h4_mem_address;
    end
    assign h4_mem_readdata = ram4[ra4_r];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int j = 0; j < 2048; j++) ram1[j] <= init_word(j);
        end else if (h1_mem_clken && h1_mem_chipselect && h1_mem_write) begin
            for (int c = 0; c < 4; c++)
                if (h1_mem_byteenable[c]) ram1[h1_mem_address][8*c +: 8] <= h1_mem_writedata[8*c +: 8];
        end
        ra1_r <= h1_mem_address;
    end
    assign h1_mem_readdata = ram1[ra1_r];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [10:0] a0, input logic [3:0] be0,
                         input logic [31:0] wd0, input logic r1, input logic w1, input logic [10:0] a1,
                         input logic [3:0] be1, input logic [31:0] wd1);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = wd0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = wd1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 11'h0, 4'h0, 32'h0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    endtask

    task automatic both_read();
        drive(1'b1, 1'b0, 11'd10, 4'hF, 32'h0, 1'b1, 1'b0, 11'd20, 4'hF, 32'h0);
    endtask

    // Reference arbitration from grant history: -1 idle, 0/1 granted master.
    int hist[$];

    function automatic int predict(input logic q0, input logic q1);
        int last;
        int streak;
        if (!q0 && !q1) return -1;
        if (q0 && !q1) return 0;
        if (!q0 && q1) return 1;
        last = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] >= 0) begin
                last = hist[k];
                break;
            end
        end
        streak = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] != last || streak >= MAXH) break;
            streak++;
        end
        return (streak >= 1 && streak < MAXH) ? last : 1 - last;
    endfunction

    typedef struct {
        logic        r0, w0;
        logic [10:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic        r1, w1;
        logic [10:0] a1;
        logic        ew0, ew1, ecs, ewe, chk_addr;
        logic [10:0] eaddr;
        logic        ev0, ev1;
        logic [31:0] edata;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] sb [0:2047];

    initial begin
        int p4, p1, e4, e1, pend, g;
        logic [31:0] exp_data;
        logic [10:0] ga;
        logic [3:0]  gbe;
        logic [31:0] gwd;
        logic        gw;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 2048; i++) sb[i] = init_word(i);

        //            r0    w0    a0       be0   wd0            r1    w1    a1       ew0   ew1   ecs   ewe   chka  eaddr    ev0   ev1   edata
        tbl[0]  = '{1'b1, 1'b0, 11'h005, 4'hF, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h005, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 11'h000, 4'h0, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 32'hC0DE0005};
        tbl[2]  = '{1'b0, 1'b1, 11'h7FF, 4'hF, 32'hDEADBEEF,  1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h7FF, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h7FF, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 11'h000, 4'h0, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 1'b1, 11'h7FF, 4'h3, 32'h00001234,  1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h7FF, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h7FF, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 11'h000, 4'h0, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 32'hDEAD1234};
        tbl[8]  = '{1'b0, 1'b0, 11'h000, 4'h0, 32'h0,         1'b1, 1'b0, 11'h005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h005, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 11'h006, 4'hF, 32'h0,         1'b1, 1'b0, 11'h007, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11'h007, 1'b0, 1'b1, 32'hC0DE0005};
        tbl[10] = '{1'b0, 1'b0, 11'h000, 4'h0, 32'h0,         1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 32'hC0DE0007};

        // Reset state
        reset = 1'b1;
        ram_init = 1'b1;
        idle();
        @(posedge clk); #1;
        ram_init = 1'b0;
        @(negedge clk);
        check1("rst_h4_wait0", h4_m0_waitrequest, 1'b0);
        check1("rst_h4_wait1", h4_m1_waitrequest, 1'b0);
        check1("rst_h4_rdv0", h4_m0_readdatavalid, 1'b0);
        check1("rst_h4_rdv1", h4_m1_readdatavalid, 1'b0);
        check1("rst_h4_cs", h4_mem_chipselect, 1'b0);
        check1("rst_h4_we", h4_mem_write, 1'b0);
        check1("h4_clken", h4_mem_clken, 1'b1);
        check1("h1_clken", h1_mem_clken, 1'b1);
        check1("rst_h1_cs", h1_mem_chipselect, 1'b0);

        // Table-driven directed vectors (MAX_HOLD=4 instance)
        for (int v = 0; v < 11; v++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            drive(tbl[v].r0, tbl[v].w0, tbl[v].a0, tbl[v].be0, tbl[v].wd0,
                  tbl[v].r1, tbl[v].w1, tbl[v].a1, 4'hF, 32'h0);
            @(negedge clk);
            check1($sformatf("v%0d_wait0", v), h4_m0_waitrequest, tbl[v].ew0);
            check1($sformatf("v%0d_wait1", v), h4_m1_waitrequest, tbl[v].ew1);
            check1($sformatf("v%0d_cs", v), h4_mem_chipselect, tbl[v].ecs);
            check1($sformatf("v%0d_we", v), h4_mem_write, tbl[v].ewe);
            check1($sformatf("v%0d_rdv0", v), h4_m0_readdatavalid, tbl[v].ev0);
            check1($sformatf("v%0d_rdv1", v), h4_m1_readdatavalid, tbl[v].ev1);
            if (tbl[v].chk_addr) check32($sformatf("v%0d_addr", v), 32'(h4_mem_address), 32'(tbl[v].eaddr));
            if (tbl[v].ewe) begin
                check32($sformatf("v%0d_wdata", v), h4_mem_writedata, tbl[v].wd0);
                check32($sformatf("v%0d_be", v), 32'(h4_mem_byteenable), 32'(tbl[v].be0));
            end
            if (tbl[v].ev0) check32($sformatf("v%0d_rdata0", v), h4_m0_readdata, tbl[v].edata);
            if (tbl[v].ev1) check32($sformatf("v%0d_rdata1", v), h4_m1_readdata, tbl[v].edata);
        end

        // Continuous contention after reset: MAX_HOLD=4 -> 1,1,1,1,0,0,0,0; MAX_HOLD=1 -> 1,0,1,0
        @(posedge clk); #1;
        reset = 1'b1;
        idle();
        p4 = -1;
        p1 = -1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            both_read();
            @(negedge clk);
            e4 = ((i / 4) % 2 == 0) ? 1 : 0;
            e1 = (i % 2 == 0) ? 1 : 0;
            check1($sformatf("c%0d_h4_wait0", i), h4_m0_waitrequest, e4 == 1);
            check1($sformatf("c%0d_h4_wait1", i), h4_m1_waitrequest, e4 == 0);
            check1($sformatf("c%0d_h1_wait0", i), h1_m0_waitrequest, e1 == 1);
            check1($sformatf("c%0d_h1_wait1", i), h1_m1_waitrequest, e1 == 0);
            check1($sformatf("c%0d_h4_rdv0", i), h4_m0_readdatavalid, p4 == 0);
            check1($sformatf("c%0d_h4_rdv1", i), h4_m1_readdatavalid, p4 == 1);
            check1($sformatf("c%0d_h1_rdv0", i), h1_m0_readdatavalid, p1 == 0);
            check1($sformatf("c%0d_h1_rdv1", i), h1_m1_readdatavalid, p1 == 1);
            if (p4 == 0) check32($sformatf("c%0d_h4_rd0", i), h4_m0_readdata, init_word(10));
            if (p4 == 1) check32($sformatf("c%0d_h4_rd1", i), h4_m1_readdata, init_word(20));
            if (p1 == 0) check32($sformatf("c%0d_h1_rd0", i), h1_m0_readdata, init_word(10));
            if (p1 == 1) check32($sformatf("c%0d_h1_rd1", i), h1_m1_readdata, init_word(20));
            p4 = e4;
            p1 = e1;
        end

        // One idle cycle clears the streak: the master other than last_gnt wins next
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        both_read();
        @(negedge clk);
        check1("idle_h4_wait1", h4_m1_waitrequest, 1'b0);
        check1("idle_h4_wait0", h4_m0_waitrequest, 1'b1);
        check1("idle_h1_wait1", h1_m1_waitrequest, 1'b0);
        check1("idle_h1_wait0", h1_m0_waitrequest, 1'b1);

        // m1 read accepted, reset the next cycle: no valid, everything waits
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 11'h0, 4'h0, 32'h0, 1'b1, 1'b0, 11'd20, 4'hF, 32'h0);
        @(negedge clk);
        check1("pre_rst_wait1", h4_m1_waitrequest, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            both_read();
            @(negedge clk);
            check1($sformatf("r%0d_h4_rdv1", k), h4_m1_readdatavalid, 1'b0);
            check1($sformatf("r%0d_h1_rdv1", k), h1_m1_readdatavalid, 1'b0);
            check1($sformatf("r%0d_h4_wait0", k), h4_m0_waitrequest, 1'b1);
            check1($sformatf("r%0d_h4_wait1", k), h4_m1_waitrequest, 1'b1);
            check1($sformatf("r%0d_h4_cs", k), h4_mem_chipselect, 1'b0);
            check1($sformatf("r%0d_h1_cs", k), h1_mem_chipselect, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check1("post_rst_h4_wait1", h4_m1_waitrequest, 1'b0);
        check1("post_rst_h4_wait0", h4_m0_waitrequest, 1'b1);
        check1("post_rst_h4_cs", h4_mem_chipselect, 1'b1);
        check1("post_rst_h1_wait1", h1_m1_waitrequest, 1'b0);

        // Random traffic against the reference model and scoreboard RAM
        @(posedge clk); #1;
        reset = 1'b1;
        idle();
        hist.delete();
        pend = -1;
        exp_data = 32'h0;
        for (int n = 0; n < 10000; n++) begin
            int op0, op1;
            @(posedge clk); #1;
            reset = 1'b0;
            op0 = int'($urandom_range(0, 3));
            op1 = int'($urandom_range(0, 3));
            drive(op0 == 1 || op0 == 3, op0 >= 2, 11'($urandom_range(0, 15)), 4'($urandom), $urandom,
                  op1 == 1 || op1 == 3, op1 >= 2, 11'($urandom_range(0, 15)), 4'($urandom), $urandom);
            @(negedge clk);
            g = predict(m0_read | m0_write, m1_read | m1_write);
            check1("rnd_wait0", h4_m0_waitrequest, (m0_read | m0_write) && g != 0);
            check1("rnd_wait1", h4_m1_waitrequest, (m1_read | m1_write) && g != 1);
            check1("rnd_cs", h4_mem_chipselect, g >= 0);
            check1("rnd_rdv0", h4_m0_readdatavalid, pend == 0);
            check1("rnd_rdv1", h4_m1_readdatavalid, pend == 1);
            if (pend == 0) check32("rnd_rdata0", h4_m0_readdata, exp_data);
            if (pend == 1) check32("rnd_rdata1", h4_m1_readdata, exp_data);
            pend = -1;
            if (g >= 0) begin
                gw  = (g == 1) ? m1_write : m0_write;
                ga  = (g == 1) ? m1_address : m0_address;
                gbe = (g == 1) ? m1_byteenable : m0_byteenable;
                gwd = (g == 1) ? m1_writedata : m0_writedata;
                check1("rnd_we", h4_mem_write, gw);
                check32("rnd_addr", 32'(h4_mem_address), 32'(ga));
                if (gw) begin
                    check32("rnd_wdata", h4_mem_writedata, gwd);
                    check32("rnd_be", 32'(h4_mem_byteenable), 32'(gbe));
                    sb[ga] = merge(sb[ga], gwd, gbe);
                end else begin
                    exp_data = sb[ga];
                    pend = g;
                end
            end
            hist.push_back(g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
